// File: rtl/video_timing_gen.sv
// Free-running H/V raster timing generator with start/stop on whole-frame boundaries.
// Define VTG_COLORBAR_EN to add the vid_rgb_o eight-bar colour pattern output.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    input  logic        en_i,
    output logic        busy_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [11:0] hcnt_o,
    output logic [10:0] vcnt_o,
    output logic        sof_o,
    output logic        eol_o
`ifdef VTG_COLORBAR_EN
    ,
    output logic [23:0] vid_rgb_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096) begin : g_h_total_bad
        $error("video_timing_gen: H_TOTAL must not exceed 4096");
    end
    if (V_TOTAL > 2048) begin : g_v_total_bad
        $error("video_timing_gen: V_TOTAL must not exceed 2048");
    end

    // One extra bit so sync-end bounds equal to the full total still compare correctly
    localparam logic [12:0] H_ACT_W = 13'(H_ACTIVE);
    localparam logic [12:0] H_SS_W  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE_W  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_W = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS_W  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE_W  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);

    localparam logic [1:0] BLANK_RST = 2'b11;
    localparam logic [2:0] SYNC_RST  = {1'b0, ~VS_POL, ~HS_POL};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        busy_q, busy_d;
    logic [1:0]  vh_blank_q, vh_blank_d;
    logic [2:0]  dvh_sync_q, dvh_sync_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;

    logic h_last, v_last, hblank, vblank, de, hs_act, vs_act, active;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign hblank = ({1'b0, h_q} >= H_ACT_W);
    assign vblank = ({1'b0, v_q} >= V_ACT_W);
    assign de     = ~hblank & ~vblank;
    assign hs_act = ({1'b0, h_q} >= H_SS_W) && ({1'b0, h_q} < H_SE_W);
    assign vs_act = ({1'b0, v_q} >= V_SS_W) && ({1'b0, v_q} < V_SE_W);
    assign active = (state_q != IDLE);

`ifdef VTG_COLORBAR_EN
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  bar;
    logic [23:0] bar_rgb;

    assign bar = 3'((int'(h_q) * 8) / H_ACTIVE);

    always_comb begin
        case (bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        busy_d     = busy_q;
        vh_blank_d = vh_blank_q;
        dvh_sync_d = dvh_sync_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
`ifdef VTG_COLORBAR_EN
        rgb_d      = rgb_q;
`endif
        if (cen_i) begin
            // Ports show the decode of the counter position held this cycle
            busy_d     = active;
            vh_blank_d = active ? {vblank, hblank} : BLANK_RST;
            dvh_sync_d = active ? {de, vs_act ? VS_POL : ~VS_POL, hs_act ? HS_POL : ~HS_POL}
                                : SYNC_RST;
            hcnt_d     = active ? h_q : 12'd0;
            vcnt_d     = active ? v_q : 11'd0;
            sof_d      = active && (h_q == 12'd0) && (v_q == 11'd0);
            eol_d      = active && h_last;
`ifdef VTG_COLORBAR_EN
            rgb_d      = (active && de) ? bar_rgb : 24'h000000;
`endif
            case (state_q)
                IDLE: begin
                    h_d = 12'd0;
                    v_d = 11'd0;
                    if (en_i) state_d = RUN;
                end
                RUN, DRAIN: begin
                    h_d = h_last ? 12'd0 : h_q + 12'd1;
                    if (h_last) v_d = v_last ? 11'd0 : v_q + 11'd1;
                    if (en_i)
                        state_d = RUN;
                    else if (state_q == DRAIN && h_last && v_last)
                        state_d = IDLE;
                    else
                        state_d = DRAIN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            h_q        <= 12'd0;
            v_q        <= 11'd0;
            busy_q     <= 1'b0;
            vh_blank_q <= BLANK_RST;
            dvh_sync_q <= SYNC_RST;
            hcnt_q     <= 12'd0;
            vcnt_q     <= 11'd0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
`ifdef VTG_COLORBAR_EN
            rgb_q      <= 24'h000000;
`endif
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            busy_q     <= busy_d;
            vh_blank_q <= vh_blank_d;
            dvh_sync_q <= dvh_sync_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
`ifdef VTG_COLORBAR_EN
            rgb_q      <= rgb_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign vh_blank_o = vh_blank_q;
    assign dvh_sync_o = dvh_sync_q;
    assign hcnt_o     = hcnt_q;
    assign vcnt_o     = vcnt_q;
    assign sof_o      = sof_q;
    assign eol_o      = eol_q;
`ifdef VTG_COLORBAR_EN
    assign vid_rgb_o  = rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a 14x7 raster (H 8/2/2/2, V 4/1/1/1).
module tb_video_timing_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cen_i = 1'b1;
    logic        en_i = 1'b0;
    logic        busy_o;
    logic [1:0]  vh_blank_o;
    logic [2:0]  dvh_sync_o;
    logic [11:0] hcnt_o;
    logic [10:0] vcnt_o;
    logic        sof_o;
    logic        eol_o;
`ifdef VTG_COLORBAR_EN
    logic [23:0] vid_rgb_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .cen_i(cen_i),
        .en_i(en_i),
        .busy_o(busy_o),
        .vh_blank_o(vh_blank_o),
        .dvh_sync_o(dvh_sync_o),
        .hcnt_o(hcnt_o),
        .vcnt_o(vcnt_o),
        .sof_o(sof_o),
        .eol_o(eol_o)
`ifdef VTG_COLORBAR_EN
        ,
        .vid_rgb_o(vid_rgb_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // {busy, Vblank, Hblank, D_sync, Vsync, Hsync, hcnt, vcnt, sof, eol}
    logic [30:0] got;
    assign got = {busy_o, vh_blank_o, dvh_sync_o, hcnt_o, vcnt_o, sof_o, eol_o};

    localparam logic [30:0] RST_VEC = {1'b0, 2'b11, 3'b000, 12'd0, 11'd0, 1'b0, 1'b0};

    function automatic logic [30:0] exp_vec(input int k);
        int  h, v;
        logic hb, vb, hs, vs;
        h  = k % 14;
        v  = (k / 14) % 7;
        hb = (h >= 8);
        vb = (v >= 4);
        hs = (h >= 10) && (h <= 11);
        vs = (v == 5);
        return {1'b1, vb, hb, ~hb & ~vb, vs, hs, 12'(h), 11'(v), (h == 0) && (v == 0), (h == 13)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i   = 1'b0;
        cen_i  = 1'b1;
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (got !== RST_VEC) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, RST_VEC);
            end
        end
    endtask

    task automatic test_run();
        en_i = 1'b1;
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL run_start_latency got=%h exp=%h", got, RST_VEC);
        end
        for (int k = 0; k <= 98; k++) begin
            tick();
            vectors++;
            if (got !== exp_vec(k)) begin
                miscompares++;
                $display("[TB] FAIL run_frame k=%0d got=%h exp=%h", k, got, exp_vec(k));
            end
        end
    endtask

    // Continues from output (0,0) of the second frame left by test_run
    task automatic test_drain();
        for (int k = 1; k <= 97; k++) begin
            tick();
            vectors++;
            if (got !== exp_vec(k)) begin
                miscompares++;
                $display("[TB] FAIL drain_frame k=%0d got=%h exp=%h", k, got, exp_vec(k));
            end
            if (k == 31) en_i = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (got !== RST_VEC) begin
                miscompares++;
                $display("[TB] FAIL drain_idle cyc=%0d got=%h exp=%h", i, got, RST_VEC);
            end
        end
    endtask

    task automatic test_back_to_back();
        en_i = 1'b1;
        tick();
        for (int k = 0; k <= 98 + 97; k++) begin
            tick();
            vectors++;
            if (got !== exp_vec(k)) begin
                miscompares++;
                $display("[TB] FAIL b2b_frame k=%0d got=%h exp=%h", k, got, exp_vec(k));
            end
            if (k == 50) en_i = 1'b0;
            if (k == 80) en_i = 1'b1;
            if (k == 98) en_i = 1'b0;
        end
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL b2b_stop got=%h exp=%h", got, RST_VEC);
        end
    endtask

    task automatic test_cen();
        logic [30:0] prev;
        prev  = RST_VEC;
        en_i  = 1'b1;
        cen_i = 1'b1;
        tick();
        for (int k = 0; k < 98; k++) begin
            cen_i = 1'b0;
            tick();
            vectors++;
            if (got !== prev) begin
                miscompares++;
                $display("[TB] FAIL cen_hold k=%0d got=%h exp=%h", k, got, prev);
            end
            cen_i = 1'b1;
            tick();
            vectors++;
            if (got !== exp_vec(k)) begin
                miscompares++;
                $display("[TB] FAIL cen_step k=%0d got=%h exp=%h", k, got, exp_vec(k));
            end
            prev = exp_vec(k);
            en_i = 1'b0;
        end
        cen_i = 1'b0;
        tick();
        vectors++;
        if (got !== exp_vec(97)) begin
            miscompares++;
            $display("[TB] FAIL cen_last_hold got=%h exp=%h", got, exp_vec(97));
        end
        cen_i = 1'b1;
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL cen_stop got=%h exp=%h", got, RST_VEC);
        end
    endtask

    task automatic test_reset_mid();
        en_i = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) tick();
        vectors++;
        if (got !== exp_vec(19)) begin
            miscompares++;
            $display("[TB] FAIL mid_position got=%h exp=%h", got, exp_vec(19));
        end
        rst_ni = 1'b0;
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL mid_reset got=%h exp=%h", got, RST_VEC);
        end
        rst_ni = 1'b1;
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL mid_restart_latency got=%h exp=%h", got, RST_VEC);
        end
        tick();
        vectors++;
        if (got !== exp_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL mid_restart got=%h exp=%h", got, exp_vec(0));
        end
        en_i = 1'b0;
        for (int k = 1; k <= 97; k++) tick();
        tick();
        vectors++;
        if (got !== RST_VEC) begin
            miscompares++;
            $display("[TB] FAIL mid_drain_stop got=%h exp=%h", got, RST_VEC);
        end
    endtask

`ifdef VTG_COLORBAR_EN
    task automatic test_colorbar();
        logic [23:0] bars [8];
        logic [23:0] exp_rgb;
        int h, v;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        vectors++;
        if (vid_rgb_o !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL rgb_idle got=%h exp=000000", vid_rgb_o);
        end
        en_i = 1'b1;
        tick();
        for (int k = 0; k < 98; k++) begin
            tick();
            h = k % 14;
            v = k / 14;
            exp_rgb = (h < 8 && v < 4) ? bars[h] : 24'h000000;
            vectors++;
            if (vid_rgb_o !== exp_rgb) begin
                miscompares++;
                $display("[TB] FAIL rgb k=%0d got=%h exp=%h", k, vid_rgb_o, exp_rgb);
            end
            en_i = 1'b0;
        end
        tick();
    endtask
`endif

    initial begin
        $display("[TB] video_timing_gen directed bench start");
        test_reset();
        test_run();
        test_drain();
        test_back_to_back();
        test_cen();
        test_reset_mid();
`ifdef VTG_COLORBAR_EN
        test_colorbar();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
